// File: rtl/jtag_dp_sequencer_pkg.sv
// Shared jtagIF command/ack encodings, sequencer state encodings and the
// command-field bundle the sequencer presents to jtagIF.
package jtag_dp_sequencer_pkg;

  localparam logic [1:0] JTAG_CMD_IR     = 2'd0;
  localparam logic [1:0] JTAG_CMD_TFR    = 2'd1;
  localparam logic [1:0] JTAG_CMD_READID = 2'd3;

  localparam logic [2:0] ACK_OK   = 3'b010;
  localparam logic [2:0] ACK_WAIT = 3'b001;

  localparam logic [1:0] DP_RDBUFF = 2'b11;

  // Each *_WT state is encoded as its *_GO state plus one.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IR_GO  = 3'd1;
  localparam logic [2:0] ST_IR_WT  = 3'd2;
  localparam logic [2:0] ST_TFR_GO = 3'd3;
  localparam logic [2:0] ST_TFR_WT = 3'd4;
  localparam logic [2:0] ST_RB_GO  = 3'd5;
  localparam logic [2:0] ST_RB_WT  = 3'd6;
  localparam logic [2:0] ST_RESP   = 3'd7;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [1:0]  addr32;
    logic        rnw;
    logic        apndp;
    logic [31:0] dwrite;
  } jtag_cmd_t;

  function automatic jtag_cmd_t ir_cmd(input logic [3:0] ir);
    jtag_cmd_t c;
    c.cmd    = JTAG_CMD_IR;
    c.addr32 = 2'b00;
    c.rnw    = 1'b0;
    c.apndp  = 1'b0;
    c.dwrite = {28'b0, ir};
    return c;
  endfunction

  function automatic jtag_cmd_t tfr_cmd(input logic apndp, input logic rnw,
                                        input logic [1:0] addr32, input logic [31:0] wdata);
    jtag_cmd_t c;
    c.cmd    = JTAG_CMD_TFR;
    c.addr32 = addr32;
    c.rnw    = rnw;
    c.apndp  = apndp;
    c.dwrite = rnw ? 32'h0 : wdata;
    return c;
  endfunction

  function automatic jtag_cmd_t rb_cmd();
    return tfr_cmd(1'b0, 1'b1, DP_RDBUFF, 32'h0);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jtag_dp_sequencer.sv
// Runs one host DP/AP access through jtagIF: IR select, transfer with WAIT
// retry, RDBUFF completion of posted AP reads, then a single response strobe.
module jtag_dp_sequencer
  import jtag_dp_sequencer_pkg::*;
#(
  parameter int unsigned MAX_WAIT_RETRY = 16,
  parameter logic [3:0]  IR_DPACC       = 4'hA,
  parameter logic [3:0]  IR_APACC       = 4'hB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cfg_dev,
  input  logic [2:0]  cfg_ndevs,
  input  logic [29:0] cfg_irlenx,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_apndp,
  input  logic        req_rnw,
  input  logic [1:0]  req_addr32,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic [7:0]  rsp_retries,
  output logic [1:0]  cmd,
  output logic [1:0]  addr32,
  output logic        rnw,
  output logic        apndp,
  output logic [31:0] dwrite,
  output logic        go,
  output logic [2:0]  dev,
  output logic [2:0]  ndevs,
  output logic [29:0] irlenx,
  input  logic [2:0]  ack,
  input  logic [31:0] dread,
  input  logic        done
);

  logic [2:0]  state;
  jtag_cmd_t   cur;
  logic        a_apndp;
  logic        a_rnw;
  logic [1:0]  a_addr32;
  logic [31:0] a_wdata;
  logic        ir_valid;
  logic [3:0]  ir_cached;
  logic [2:0]  ir_dev;
  logic        rb_after_ir;
  logic [7:0]  retry_cnt;

  logic [3:0]  req_ir;
  logic        ir_needed;
  logic        can_retry;
  logic        ap_read;

  assign req_ir    = req_apndp ? IR_APACC : IR_DPACC;
  assign ir_needed = !ir_valid || (ir_cached != req_ir) || (ir_dev != cfg_dev);
  assign can_retry = 32'(retry_cnt) < MAX_WAIT_RETRY;
  assign ap_read   = a_apndp && a_rnw;

  assign cmd    = cur.cmd;
  assign addr32 = cur.addr32;
  assign rnw    = cur.rnw;
  assign apndp  = cur.apndp;
  assign dwrite = cur.dwrite;
  assign ndevs  = cfg_ndevs;
  assign irlenx = cfg_irlenx;

  // GO holds go high until jtagIF leaves idle (done=0); WT waits for done=1
  // and consumes ack/dread in that cycle. cur stays put across the pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur         <= '0;
      go          <= 1'b0;
      dev         <= 3'd0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_ack     <= 3'd0;
      rsp_rdata   <= 32'h0;
      rsp_retries <= 8'd0;
      a_apndp     <= 1'b0;
      a_rnw       <= 1'b0;
      a_addr32    <= 2'b00;
      a_wdata     <= 32'h0;
      ir_valid    <= 1'b0;
      ir_cached   <= 4'h0;
      ir_dev      <= 3'd0;
      rb_after_ir <= 1'b0;
      retry_cnt   <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_apndp     <= req_apndp;
            a_rnw       <= req_rnw;
            a_addr32    <= req_addr32;
            a_wdata     <= req_wdata;
            dev         <= cfg_dev;
            retry_cnt   <= 8'd0;
            rb_after_ir <= 1'b0;
            req_ready   <= 1'b0;
            go          <= 1'b1;
            if (ir_needed) begin
              cur   <= ir_cmd(req_ir);
              state <= ST_IR_GO;
            end else begin
              cur   <= tfr_cmd(req_apndp, req_rnw, req_addr32, req_wdata);
              state <= ST_TFR_GO;
            end
          end
        end
        ST_IR_GO, ST_TFR_GO, ST_RB_GO: begin
          if (!done) begin
            go    <= 1'b0;
            state <= state + 3'd1;
          end
        end
        ST_IR_WT: begin
          if (done) begin
            ir_valid  <= 1'b1;
            ir_cached <= cur.dwrite[3:0];
            ir_dev    <= dev;
            go        <= 1'b1;
            if (rb_after_ir) begin
              cur   <= rb_cmd();
              state <= ST_RB_GO;
            end else begin
              cur   <= tfr_cmd(a_apndp, a_rnw, a_addr32, a_wdata);
              state <= ST_TFR_GO;
            end
          end
        end
        ST_TFR_WT, ST_RB_WT: begin
          if (done) begin
            if (ack == ACK_WAIT && can_retry) begin
              retry_cnt <= sat_inc8(retry_cnt);
              go        <= 1'b1;
              state     <= state - 3'd1;
            end else if (ack == ACK_OK && state == ST_TFR_WT && ap_read) begin
              // The posted AP read result is collected from DP RDBUFF, which needs DPACC.
              go <= 1'b1;
              if (ir_cached == IR_DPACC) begin
                cur   <= rb_cmd();
                state <= ST_RB_GO;
              end else begin
                cur         <= ir_cmd(IR_DPACC);
                rb_after_ir <= 1'b1;
                state       <= ST_IR_GO;
              end
            end else begin
              rsp_ack     <= ack;
              rsp_rdata   <= (ack == ACK_OK && a_rnw) ? dread : 32'h0;
              rsp_retries <= retry_cnt;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
